// File: rtl/trigger_latency_meter.sv
// ============================================================================
// Module      : trigger_latency_meter
// Description : Counts target-clock rising edges between a trigger rising edge
//               and a target response rising edge, with optional timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trigger_latency_meter #(
    parameter int unsigned      CNT_W           = 32,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter logic [CNT_W-1:0] DEFAULT_TIMEOUT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             target_clock,
    input  logic             trig,
    input  logic             event_in,
    input  logic             arm,
    input  logic [CNT_W-1:0] timeout,
    input  logic             set_timeout,
    output logic             busy,
    output logic             valid,
    output logic             timed_out,
    output logic [CNT_W-1:0] count
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_armed = 2'd1;
    localparam logic [1:0] c_st_count = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    // Bit order {event, trig, target clock}; all three share one chain so
    // their relative timing survives synchronisation.
    logic [2:0] w_pins;
    logic [2:0] r_sync [SYNC_STAGES];
    logic [2:0] r_hist;
    logic [2:0] w_rise;
    logic       w_tick;
    logic       w_trig_rise;
    logic       w_evt_rise;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_timeout;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_valid;
    logic             r_timed_out;
    logic             w_to_hit;

    assign w_pins = {event_in, trig, target_clock};

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) r_sync[gi] <= '0;
                    else     r_sync[gi] <= w_pins;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) r_sync[gi] <= '0;
                    else     r_sync[gi] <= r_sync[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) r_hist <= '0;
        else     r_hist <= r_sync[SYNC_STAGES-1];
    end

    assign w_rise      = r_sync[SYNC_STAGES-1] & ~r_hist;
    assign w_tick      = w_rise[0];
    assign w_trig_rise = w_rise[1];
    assign w_evt_rise  = w_rise[2];

    always_ff @(posedge clk) begin
        if (rst)              r_timeout <= DEFAULT_TIMEOUT;
        else if (set_timeout) r_timeout <= timeout;
    end

    // Saturating increment; the timeout compares against the value about to be stored.
    assign w_cnt_inc = (w_tick && (r_count != c_cnt_max)) ? r_count + 1'b1 : r_count;
    assign w_to_hit  = (r_timeout != '0) && (w_cnt_inc >= r_timeout);

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (arm) w_state_nxt = c_st_armed;
            end
            c_st_armed: begin
                if (arm)              w_state_nxt = c_st_armed;
                else if (w_trig_rise) w_state_nxt = c_st_count;
            end
            c_st_count: begin
                if (arm)                        w_state_nxt = c_st_armed;
                else if (w_evt_rise || w_to_hit) w_state_nxt = c_st_done;
            end
            c_st_done: begin
                if (arm) w_state_nxt = c_st_armed;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_timed_out <= 1'b0;
        end else if (arm) begin
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_timed_out <= 1'b0;
        end else if (r_state == c_st_count) begin
            r_count <= w_cnt_inc;
            if (w_evt_rise) begin
                r_valid     <= 1'b1;
                r_timed_out <= 1'b0;
            end else if (w_to_hit) begin
                r_valid     <= 1'b1;
                r_timed_out <= 1'b1;
            end
        end
    end

    always_comb begin
        busy      = (r_state == c_st_armed) || (r_state == c_st_count);
        valid     = r_valid;
        timed_out = r_timed_out;
        count     = r_count;
    end

endmodule

`default_nettype wire

// File: tb/tb_trigger_latency_meter.sv
// ============================================================================
// Module      : tb_trigger_latency_meter
// Description : Self-checking bench for trigger_latency_meter (32-bit and 4-bit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trigger_latency_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        target_clock = 1'b0;
    logic        trig = 1'b0;
    logic        event_in = 1'b0;
    logic        arm = 1'b0;
    logic [31:0] timeout = '0;
    logic        set_timeout = 1'b0;

    logic        busy, valid, timed_out;
    logic [31:0] count;
    logic        busy_b, valid_b, timed_out_b;
    logic [3:0]  count_b;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] tmo;
        int          edges;
        bit          evt;
        logic [31:0] exp_cnt;
        bit          exp_to;
    } vec_t;

    typedef struct {
        logic [31:0] cnt;
        bit          to;
    } exp_t;

    vec_t vecs[5];
    exp_t sb[$];

    trigger_latency_meter #(.CNT_W(32), .SYNC_STAGES(2), .DEFAULT_TIMEOUT(32'd0)) dut (
        .clk(clk), .rst(rst), .target_clock(target_clock), .trig(trig),
        .event_in(event_in), .arm(arm), .timeout(timeout), .set_timeout(set_timeout),
        .busy(busy), .valid(valid), .timed_out(timed_out), .count(count)
    );

    trigger_latency_meter #(.CNT_W(4), .SYNC_STAGES(2), .DEFAULT_TIMEOUT(4'd0)) dut_b (
        .clk(clk), .rst(rst), .target_clock(target_clock), .trig(trig),
        .event_in(event_in), .arm(arm), .timeout(timeout[3:0]), .set_timeout(set_timeout),
        .busy(busy_b), .valid(valid_b), .timed_out(timed_out_b), .count(count_b)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) begin
            target_clock = 1'b1;
            repeat (3) step();
            target_clock = 1'b0;
            repeat (3) step();
        end
    endtask

    task automatic set_tmo(input logic [31:0] v);
        timeout = v;
        set_timeout = 1'b1;
        step();
        set_timeout = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic start_trig();
        trig = 1'b1;
        step();
        step();
    endtask

    task automatic quiesce();
        trig = 1'b0;
        event_in = 1'b0;
        target_clock = 1'b0;
        repeat (6) step();
    endtask

    task automatic push_exp(input logic [31:0] c, input bit t);
        exp_t e;
        e.cnt = c;
        e.to  = t;
        sb.push_back(e);
    endtask

    task automatic wait_and_check(input string name);
        exp_t e;
        int k = 0;
        while (!valid && k < 40) begin
            step();
            k++;
        end
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            if (!valid) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: valid never rose (got 0 expected 1)", name);
            end else begin
                chk({name, ".count"}, 64'(count), 64'(e.cnt));
                chk({name, ".timed_out"}, 64'(timed_out), 64'(e.to));
                chk({name, ".busy"}, 64'(busy), 64'd0);
            end
        end
    endtask

    initial begin
        vecs[0] = '{tmo: 32'd0,   edges: 100, evt: 1'b1, exp_cnt: 32'd100, exp_to: 1'b0};
        vecs[1] = '{tmo: 32'd50,  edges: 60,  evt: 1'b0, exp_cnt: 32'd50,  exp_to: 1'b1};
        vecs[2] = '{tmo: 32'd0,   edges: 7,   evt: 1'b1, exp_cnt: 32'd7,   exp_to: 1'b0};
        vecs[3] = '{tmo: 32'd200, edges: 37,  evt: 1'b1, exp_cnt: 32'd37,  exp_to: 1'b0};
        vecs[4] = '{tmo: 32'd10,  edges: 9,   evt: 1'b1, exp_cnt: 32'd9,   exp_to: 1'b0};

        repeat (3) step();
        rst = 1'b0;
        step();
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.valid", 64'(valid), 64'd0);
        chk("reset.timed_out", 64'(timed_out), 64'd0);
        chk("reset.count", 64'(count), 64'd0);
        chk("reset.count_b", 64'(count_b), 64'd0);

        for (int i = 0; i < 5; i++) begin
            set_tmo(vecs[i].tmo);
            do_arm();
            chk($sformatf("vec%0d.armed_busy", i), 64'(busy), 64'd1);
            start_trig();
            edges(vecs[i].edges);
            if (vecs[i].evt) event_in = 1'b1;
            push_exp(vecs[i].exp_cnt, vecs[i].exp_to);
            wait_and_check($sformatf("vec%0d", i));
            quiesce();
        end

        // Trigger already high at arm must not start counting.
        set_tmo(32'd0);
        trig = 1'b1;
        repeat (6) step();
        do_arm();
        edges(20);
        chk("trig_high.busy", 64'(busy), 64'd1);
        chk("trig_high.count", 64'(count), 64'd0);
        chk("trig_high.valid", 64'(valid), 64'd0);
        trig = 1'b0;
        repeat (6) step();
        start_trig();
        edges(7);
        event_in = 1'b1;
        push_exp(32'd7, 1'b0);
        wait_and_check("trig_rearm");
        quiesce();

        // Event while still armed is ignored.
        do_arm();
        event_in = 1'b1;
        repeat (8) step();
        chk("evt_armed.busy", 64'(busy), 64'd1);
        chk("evt_armed.valid", 64'(valid), 64'd0);
        event_in = 1'b0;
        repeat (6) step();
        start_trig();
        edges(5);
        event_in = 1'b1;
        push_exp(32'd5, 1'b0);
        wait_and_check("evt_armed_then");
        quiesce();

        // Event coincident with the tick that reaches the timeout.
        set_tmo(32'd50);
        do_arm();
        start_trig();
        edges(49);
        target_clock = 1'b1;
        event_in = 1'b1;
        push_exp(32'd50, 1'b0);
        wait_and_check("coincident");
        quiesce();

        // Re-arm mid-count.
        set_tmo(32'd0);
        do_arm();
        start_trig();
        edges(30);
        chk("mid.count30", 64'(count), 64'd30);
        do_arm();
        chk("mid.busy", 64'(busy), 64'd1);
        chk("mid.count", 64'(count), 64'd0);
        chk("mid.valid", 64'(valid), 64'd0);
        trig = 1'b0;
        repeat (6) step();
        start_trig();
        edges(12);
        event_in = 1'b1;
        push_exp(32'd12, 1'b0);
        wait_and_check("rearm12");
        quiesce();

        // Reset mid-count clears outputs and the timeout register.
        set_tmo(32'd100);
        do_arm();
        start_trig();
        edges(10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.valid", 64'(valid), 64'd0);
        chk("rst.timed_out", 64'(timed_out), 64'd0);
        chk("rst.count", 64'(count), 64'd0);
        quiesce();
        do_arm();
        start_trig();
        edges(120);
        event_in = 1'b1;
        push_exp(32'd120, 1'b0);
        wait_and_check("rst_tmo_default");
        quiesce();

        // 4-bit instance saturates at 15.
        set_tmo(32'd0);
        do_arm();
        start_trig();
        edges(20);
        event_in = 1'b1;
        repeat (8) step();
        chk("sat.count_b", 64'(count_b), 64'd15);
        chk("sat.valid_b", 64'(valid_b), 64'd1);
        chk("sat.timed_out_b", 64'(timed_out_b), 64'd0);
        quiesce();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
